// File: rtl/hilo_mac_unit.sv
// hilo_mac_unit
//   Multi-cycle multiply / multiply-accumulate engine that owns the architectural
//   HI/LO register pair. A radix-2 shift-add datapath produces one multiplier bit
//   per cycle. Control stalls the pipeline while busy=1.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset (aborts any operation, clears HI/LO)
//   start   one-cycle request, sampled only in IDLE
//   op      000 MUL  001 MULT  010 MULTU  011 MADD  100 MADDU  101 MTHI  110 MTLO
//           (111 is ignored)
//   a, b    operands (rs, rt); MTHI/MTLO use a only
//   busy    high from the cycle after an accepted multiply start until done
//   done    one-cycle pulse; hi/lo already hold the new value in that cycle
//   hi, lo  architectural HI/LO
//   result  LO value of the last completed multiply, for MUL writeback
//
// Handshake: start is accepted on a rising edge only while the FSM is IDLE
//   (including the cycle in which done=1). Starts seen while busy are dropped.
//
// Configuration
//   EARLY_TERM_EN  when defined, CALC exits as soon as the remaining multiplier
//                  bits are zero; ACC realigns the product so results match the
//                  fixed-latency build exactly.

module hilo_mac_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;
  logic               sign;
  logic [2:0]         op_q;

  // Operand conditioning at start: signed ops work on magnitudes.
  logic             in_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign in_signed = (op == OP_MUL) || (op == OP_MULT) || (op == OP_MADD);
  assign a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;

  // One shift-add step: add multiplicand into the upper half (keeping the
  // carry), then shift the whole product right by one.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               calc_exit;

  assign add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                     (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_next = {add_sum, prod[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
  assign calc_exit = (cnt == LAST_CNT) || (mplier[WIDTH-1:1] == '0);
`else
  assign calc_exit = (cnt == LAST_CNT);
`endif

  // Final value: realign (early exit only), apply sign, optionally accumulate.
  logic [2*WIDTH-1:0] aligned;
  logic [2*WIDTH-1:0] signed_prod;
  logic [2*WIDTH-1:0] final_val;

`ifdef EARLY_TERM_EN
  // cnt holds the index of the last processed bit; the product still needs
  // one right shift per unprocessed bit.
  assign aligned = prod >> (LAST_CNT - cnt);
`else
  assign aligned = prod;
`endif

  assign signed_prod = sign ? -aligned : aligned;
  assign final_val   = ((op_q == OP_MADD) || (op_q == OP_MADDU)) ?
                       signed_prod + {hi, lo} : signed_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      op_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                mcand  <= a_mag;
                mplier <= b_mag;
                sign   <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                op_q   <= op;
                prod   <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= S_CALC;
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          prod   <= prod_next;
          mplier <= mplier >> 1;
          if (calc_exit) begin
            state <= S_ACC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACC: begin
          hi     <= final_val[2*WIDTH-1:WIDTH];
          lo     <= final_val[WIDTH-1:0];
          result <= final_val[WIDTH-1:0];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb_hilo_mac_unit
//   Randomized and directed stimulus for hilo_mac_unit. Each issued operation
//   pushes its expected HI/LO/result/latency (from a 64-bit arithmetic model)
//   into exp_q; a monitor on the falling edge pops and compares on every done.

module tb_hilo_mac_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NONE  = 3'b111;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo, result;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_mac_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] res;
    logic         chk_res;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL spurious_done @cycle %0d: got done=1 expected no pending op", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        if (e.chk_res) check("result", result, e.res);
        check("latency", cyc - e.start_cyc + 1, e.lat);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi = '0, m_lo = '0, m_res = '0;

  function automatic int calc_iters(input logic [W-1:0] m);
    int n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n;
  endfunction

  function automatic int mult_latency(input logic [W-1:0] mag);
`ifdef EARLY_TERM_EN
    return calc_iters(mag) + 2;
`else
    return (mag == mag) ? W + 2 : W + 2;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the following falling edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t        e;
    logic [63:0] p;
    logic        is_signed;
    logic        is_mult;
    logic [W-1:0] bmag;
    is_mult   = (o != OP_MTHI) && (o != OP_MTLO);
    e.start_cyc = cyc + 1;
    e.chk_res = 1'b0;
    e.lat     = 1;
    if (o == OP_MTHI) begin
      m_hi = av;
    end else if (o == OP_MTLO) begin
      m_lo = av;
    end else begin
      is_signed = (o == OP_MUL) || (o == OP_MULT) || (o == OP_MADD);
      if (is_signed) p = 64'(longint'($signed(av)) * longint'($signed(bv)));
      else           p = {32'b0, av} * {32'b0, bv};
      if (o == OP_MADD || o == OP_MADDU) p = p + {m_hi, m_lo};
      m_hi  = p[63:32];
      m_lo  = p[31:0];
      m_res = p[31:0];
      bmag  = (is_signed && bv[W-1]) ? -bv : bv;
      e.chk_res = 1'b1;
      e.lat     = mult_latency(bmag);
    end
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.res = m_res;
    exp_q.push_back(e);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_start", busy, is_mult);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge where done=1 (so the next issue is back-to-back).
  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout @cycle %0d: got no done in %0d cycles expected done", cyc, k);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    issue(o, av, bv);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Preload HI/LO, then abort a MULT mid-CALC with a 2-cycle reset.
    run(OP_MTHI, 32'h1234_5678, 32'h0);
    run(OP_MTLO, 32'h9abc_def0, 32'h0);
    run(OP_MULT, 32'd3, 32'd5);
    @(negedge clk);
    op = OP_MULT; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_res = '0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_result", result, 0);
    repeat (40) @(negedge clk);
    check("abort_busy_later", busy, 0);

    // Directed corner cases, each issued in the cycle the previous done pulses.
    run(OP_MULT,  32'hFFFF_FFFD, 32'd7);
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OP_MTHI,  32'h1, 32'h0);
    run(OP_MTLO,  32'hFFFF_FFFF, 32'h0);
    run(OP_MADDU, 32'd1, 32'd1);
    run(OP_MADD,  32'hFFFF_FFFF, 32'd1);
    run(OP_MULTU, 32'd5, 32'd3);
    run(OP_MULTU, 32'd1, 32'd0);

    // Signed corner plus a start pulse while busy that must be dropped.
    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    op = OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reserved op: no done, no busy, no register change.
    op = OP_NONE; a = 32'h5555_5555; b = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reserved_busy", busy, 0);
    check("reserved_hi", hi, m_hi);
    check("reserved_lo", lo, m_lo);

    // Randomized mix with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(0, 255));
        2:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      run(ro, ra, rb);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog @cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
